// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
//   state_t  : controller states (IDLE / CALC / DONE)
//   MODE_SUB : subtractive Euclid algorithm select
//   MODE_BIN : binary (Stein) algorithm select
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// Combinational next-operand logic for one GCD iteration.
//   x, y    : current operands
//   k       : current count of common factors of two (Stein)
//   mode    : MODE_SUB or MODE_BIN
//   next_x  : operand X after this step
//   next_y  : operand Y after this step
//   next_k  : shift count after this step (saturates at DATA_BITS-1)
//   eq      : operands are equal, computation finished
module gcd_step
  import gcd_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int K_BITS    = $clog2(DATA_BITS)
) (
  input  logic [DATA_BITS-1:0] x,
  input  logic [DATA_BITS-1:0] y,
  input  logic [K_BITS-1:0]    k,
  input  logic                 mode,
  output logic [DATA_BITS-1:0] next_x,
  output logic [DATA_BITS-1:0] next_y,
  output logic [K_BITS-1:0]    next_k,
  output logic                 eq
);

  localparam logic [K_BITS-1:0] K_MAX = K_BITS'(DATA_BITS - 1);

  always_comb begin
    next_x = x;
    next_y = y;
    next_k = k;
    eq     = (x == y);
    if (mode == MODE_SUB) begin
      if (x > y) next_x = x - y;
      else       next_y = y - x;
    end else begin
      unique case ({x[0], y[0]})
        2'b00: begin
          next_x = x >> 1;
          next_y = y >> 1;
          if (k != K_MAX) next_k = k + 1'b1;
        end
        2'b01:   next_x = x >> 1;
        2'b10:   next_y = y >> 1;
        default: begin
          // both odd: larger minus smaller, result is even
          if (x > y) next_x = x - y;
          else       next_y = y - x;
        end
      endcase
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// Self-sequencing GCD engine: FSM controller, operand registers and
// result register.
//   clk_i, rst_i            : clock, async active-high reset
//   in_valid_i / in_ready_o : operand handshake (x_i, y_i, mode_i)
//   abort_i                 : cancel an in-progress computation
//   out_valid_o/out_ready_i : result handshake (gcd_o, iter_o)
//   busy_o                  : computation in progress
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_BITS-1:0] x_i,
  input  logic [DATA_BITS-1:0] y_i,
  input  logic                 mode_i,
  input  logic                 abort_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_BITS-1:0] gcd_o,
  output logic [CNT_BITS-1:0]  iter_o,
  output logic                 busy_o
);

  localparam int K_BITS = $clog2(DATA_BITS);
  localparam logic [CNT_BITS-1:0] ITER_MAX = '1;

  state_t state, state_nx;

  logic [DATA_BITS-1:0] x, y, next_x, next_y;
  logic [K_BITS-1:0]    k, next_k;
  logic [CNT_BITS-1:0]  iter;
  logic                 mode;
  logic                 eq;
  logic                 zero_in;

  assign zero_in = (x_i == '0) || (y_i == '0);

  gcd_step #(.DATA_BITS(DATA_BITS), .K_BITS(K_BITS)) u_step (
    .x      (x),
    .y      (y),
    .k      (k),
    .mode   (mode),
    .next_x (next_x),
    .next_y (next_y),
    .next_k (next_k),
    .eq     (eq)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid_i) state_nx = zero_in ? DONE : CALC;
      CALC: begin
        if (abort_i)  state_nx = IDLE;
        else if (eq)  state_nx = DONE;
      end
      DONE: if (out_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x      <= '0;
      y      <= '0;
      k      <= '0;
      iter   <= '0;
      mode   <= MODE_SUB;
      gcd_o  <= '0;
      iter_o <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid_i) begin
          x    <= x_i;
          y    <= y_i;
          mode <= mode_i;
          k    <= '0;
          iter <= '0;
          // a zero operand short-circuits straight to the result
          if (zero_in) begin
            gcd_o  <= x_i | y_i;
            iter_o <= '0;
          end
        end
        CALC: if (!abort_i) begin
          if (eq) begin
            gcd_o  <= x << k;
            iter_o <= iter;
          end else begin
            x <= next_x;
            y <= next_y;
            k <= next_k;
            if (iter != ITER_MAX) iter <= iter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign busy_o      = (state == CALC);
  assign out_valid_o = (state == DONE);

endmodule

// File: tb/tb_gcd_unit.sv
module tb_gcd_unit;

  localparam int DB = 8;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DB-1:0] x = '0;
  logic [DB-1:0] y = '0;
  logic          mode = 1'b0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DB-1:0] gcd;
  logic [CB-1:0] iter;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_unit #(.DATA_BITS(DB), .CNT_BITS(CB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .x_i         (x),
    .y_i         (y),
    .mode_i      (mode),
    .abort_i     (abort),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .gcd_o       (gcd),
    .iter_o      (iter),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: Euclid by remainder, independent of either hardware algorithm.
  function automatic int ref_gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of update steps each algorithm needs, unsaturated.
  function automatic int ref_steps(int a, int b, logic m);
    int n = 0;
    if (a == 0 || b == 0) return 0;
    while (a != b) begin
      if (m && a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (m && a % 2 == 0) a = a / 2;
      else if (m && b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
      n++;
    end
    return n;
  endfunction

  function automatic int ref_iter(int a, int b, logic m);
    int n = ref_steps(a, b, m);
    return (n > (1 << CB) - 1) ? (1 << CB) - 1 : n;
  endfunction

  // Edges after the accept edge until out_valid is seen.
  function automatic int ref_lat(int a, int b, logic m);
    if (a == 0 || b == 0) return 0;
    return ref_steps(a, b, m) + 1;
  endfunction

  // Present an operand pair, then scramble inputs (must not matter) and
  // wait, bounded, for the result.
  task automatic run_op(input logic [DB-1:0] a, input logic [DB-1:0] b, input logic m,
                        output logic [DB-1:0] g, output logic [CB-1:0] it, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    x = a; y = b; mode = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    x = DB'($urandom); y = DB'($urandom); mode = ~m;
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    g = gcd;
    it = iter;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drops_after_handoff", out_valid, 0);
    chk("in_ready_after_handoff", in_ready, 1);
  endtask

  initial begin
    logic [DB-1:0] g, pg, ra, rb;
    logic [CB-1:0] it, pit;
    logic          rm;
    int            lat;

    // reset state while reset is held
    #12;
    chk("rst_gcd", gcd, 0);
    chk("rst_iter", iter, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);

    // subtractive (12,8)
    run_op(12, 8, 1'b0, g, it, lat);
    chk("sub12_8_gcd", g, 4);
    chk("sub12_8_iter", it, 2);
    chk("sub12_8_latency", lat, 3);
    handoff();

    // Stein (12,8), (255,1); subtractive (255,1)
    run_op(12, 8, 1'b1, g, it, lat);
    chk("bin12_8_gcd", g, 4);
    chk("bin12_8_iter", it, 5);
    chk("bin12_8_latency", lat, 6);
    handoff();
    run_op(255, 1, 1'b1, g, it, lat);
    chk("bin255_1_gcd", g, 1);
    chk("bin255_1_iter", it, ref_iter(255, 1, 1'b1));
    handoff();
    run_op(255, 1, 1'b0, g, it, lat);
    chk("sub255_1_gcd", g, 1);
    chk("sub255_1_iter", it, 254);
    handoff();

    // zero operands: result is available right after the accept edge
    run_op(0, 9, 1'b0, g, it, lat);
    chk("zero0_9_gcd", g, 9);
    chk("zero0_9_iter", it, 0);
    chk("zero0_9_latency", lat, 0);
    handoff();
    run_op(0, 0, 1'b1, g, it, lat);
    chk("zero0_0_gcd", g, 0);
    chk("zero0_0_iter", it, 0);
    handoff();

    // backpressure: hold DONE for 10 cycles, new requests ignored
    run_op(30, 12, 1'b0, g, it, lat);
    chk("bp_gcd", g, 6);
    chk("bp_iter", it, 3);
    for (int i = 0; i < 10; i++) begin
      x = 8'd5; y = 8'd5; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_gcd_held", gcd, 6);
      chk("bp_iter_held", iter, 3);
      chk("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    handoff();
    chk("bp_no_new_accept", busy, 0);
    pg = 8'd6;
    pit = 8'd3;

    // abort on the 5th CALC cycle of subtractive (200,3)
    @(negedge clk);
    x = 8'd200; y = 8'd3; mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_busy_before", busy, 1);
      chk("abort_no_valid_before", out_valid, 0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_low", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_no_valid", out_valid, 0);
    chk("abort_gcd_kept", gcd, pg);
    chk("abort_iter_kept", iter, pit);
    run_op(9, 6, 1'b0, g, it, lat);
    chk("after_abort_gcd", g, 3);
    chk("after_abort_iter", it, ref_iter(9, 6, 1'b0));
    handoff();

    // async reset between edges mid-CALC
    @(negedge clk);
    x = 8'd200; y = 8'd3; mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_gcd", gcd, 0);
    chk("midrst_iter", iter, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(7, 7, 1'b1, g, it, lat);
    chk("eq7_7_gcd", g, 7);
    chk("eq7_7_iter", it, 0);
    chk("eq7_7_latency", lat, 1);
    handoff();

    // randomized pairs against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = DB'($urandom_range(0, 255));
      rb = DB'($urandom_range(0, 255));
      if (i % 8 == 3) ra = '0;
      rm = 1'($urandom);
      run_op(ra, rb, rm, g, it, lat);
      chk("rand_gcd", g, ref_gcd(ra, rb));
      chk("rand_iter", it, ref_iter(ra, rb, rm));
      chk("rand_latency", lat, ref_lat(ra, rb, rm));
      handoff();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
